// File: rtl/batch_dispatcher.sv
// batch_dispatcher: queues completed batches, reads each batch's owners from storage
// and hands them to the executor one at a time, releasing the slot when drained.
module batch_dispatcher #(
  parameter int TX_PER_BATCH   = 48,
  parameter int ACCOUNT_WIDTH  = 64,
  parameter int BATCH_ID_WIDTH = 8,
  parameter int CNT_WIDTH      = 6,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      batch_rdy_valid,
  input  logic [BATCH_ID_WIDTH-1:0] batch_rdy_id,
  input  logic [CNT_WIDTH-1:0]      batch_rdy_count,
  output logic                      batch_rdy_ready,
  output logic                      rd_req,
  output logic [BATCH_ID_WIDTH-1:0] rd_batch_id,
  output logic [CNT_WIDTH-1:0]      rd_index,
  input  logic [ACCOUNT_WIDTH-1:0]  rd_data,
  output logic                      exec_valid,
  input  logic                      exec_ready,
  output logic [ACCOUNT_WIDTH-1:0]  exec_owner,
  output logic [BATCH_ID_WIDTH-1:0] exec_batch_id,
  output logic [CNT_WIDTH-1:0]      exec_tx_index,
  output logic                      exec_last,
  output logic                      batch_release,
  output logic [BATCH_ID_WIDTH-1:0] batch_release_id,
  output logic                      busy,
  output logic [31:0]               tx_dispatched
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PRESENT, RELEASE} state_t;
  state_t state, state_nx;
  logic [BATCH_ID_WIDTH-1:0] fifo_id [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0]      fifo_len [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [PW:0]               level;
  logic                      full, empty, push, pop, hs;
  logic [CNT_WIDTH-1:0]      clamped, idx, cur_count;
  logic [BATCH_ID_WIDTH-1:0] cur_id;
  assign full = level == (PW+1)'(FIFO_DEPTH);
  assign empty = level == '0;
  assign batch_rdy_ready = !full;
  assign push = batch_rdy_valid && !full;
  assign pop = state == IDLE && !empty;
  assign hs = state == PRESENT && exec_ready;
  assign clamped = batch_rdy_count > CNT_WIDTH'(TX_PER_BATCH) ? CNT_WIDTH'(TX_PER_BATCH) : batch_rdy_count;
  assign rd_req = state == FETCH;
  assign rd_batch_id = rd_req ? cur_id : '0;
  assign rd_index = rd_req ? idx : '0;
  assign exec_valid = state == PRESENT;
  assign batch_release = state == RELEASE;
  assign batch_release_id = batch_release ? cur_id : '0;
  assign busy = state != IDLE || !empty;
  always_ff @(posedge clk)
    if (push) begin
      fifo_id[wr_ptr] <= batch_rdy_id;
      fifo_len[wr_ptr] <= clamped;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = fifo_len[rd_ptr] == '0 ? RELEASE : FETCH;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = PRESENT;
      PRESENT: if (exec_ready) state_nx = exec_last ? RELEASE : FETCH;
      default: state_nx = IDLE;
    endcase
  end
  // Reset drops everything in flight, including queued batches, without a release.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      cur_id <= '0;
      cur_count <= '0;
      idx <= '0;
      exec_owner <= '0;
      exec_batch_id <= '0;
      exec_tx_index <= '0;
      exec_last <= 1'b0;
      tx_dispatched <= '0;
    end else begin
      state <= state_nx;
      level <= level + (PW+1)'(push) - (PW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        cur_id <= fifo_id[rd_ptr];
        cur_count <= fifo_len[rd_ptr];
        idx <= '0;
      end
      if (state == LOAD) begin
        exec_owner <= rd_data;
        exec_batch_id <= cur_id;
        exec_tx_index <= idx;
        exec_last <= idx == cur_count - CNT_WIDTH'(1);
      end
      if (hs) tx_dispatched <= tx_dispatched + 32'd1;
      if (hs && !exec_last) idx <= idx + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_batch_dispatcher.sv
// tb_batch_dispatcher: directed table of batches plus hand sequences for stall,
// back-to-back queueing and mid-batch reset.
module tb_batch_dispatcher;
  logic        clk = 0, rst = 0;
  logic        batch_rdy_valid = 0, batch_rdy_ready;
  logic [7:0]  batch_rdy_id = 0, rd_batch_id, exec_batch_id, batch_release_id;
  logic [5:0]  batch_rdy_count = 0, rd_index, exec_tx_index;
  logic        rd_req, exec_valid, exec_ready = 0, exec_last, batch_release, busy;
  logic [63:0] rd_data = 0, exec_owner;
  logic [31:0] tx_dispatched;
  int n_cmp = 0, n_err = 0, cyc = 0;
  int rd_n, ev_n, rd_first, ev_first;
  logic [5:0]  hs_idx[$];
  logic [63:0] hs_own[$];
  logic        hs_last[$];
  logic [7:0]  hs_bid[$], rel_id[$];
  int          rel_cyc[$];

  batch_dispatcher dut (
    .clk(clk), .rst(rst), .batch_rdy_valid(batch_rdy_valid), .batch_rdy_id(batch_rdy_id),
    .batch_rdy_count(batch_rdy_count), .batch_rdy_ready(batch_rdy_ready), .rd_req(rd_req),
    .rd_batch_id(rd_batch_id), .rd_index(rd_index), .rd_data(rd_data), .exec_valid(exec_valid),
    .exec_ready(exec_ready), .exec_owner(exec_owner), .exec_batch_id(exec_batch_id),
    .exec_tx_index(exec_tx_index), .exec_last(exec_last), .batch_release(batch_release),
    .batch_release_id(batch_release_id), .busy(busy), .tx_dispatched(tx_dispatched));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] owner(input logic [7:0] id, input logic [5:0] ix);
    return 64'hA000_0000_0000_0000 | (64'(id) << 16) | 64'(ix);
  endfunction

  // Storage model: data valid exactly one cycle after the read strobe.
  always @(posedge clk) rd_data <= rd_req ? owner(rd_batch_id, rd_index) : 64'd0;

  always @(negedge clk) if (rst) begin
    if (rd_req) begin rd_n++; if (rd_first < 0) rd_first = cyc; end
    if (exec_valid) begin ev_n++; if (ev_first < 0) ev_first = cyc; end
    if (exec_valid && exec_ready) begin
      hs_idx.push_back(exec_tx_index); hs_own.push_back(exec_owner);
      hs_last.push_back(exec_last); hs_bid.push_back(exec_batch_id);
    end
    if (batch_release) begin rel_id.push_back(batch_release_id); rel_cyc.push_back(cyc); end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin n_err++; $display("FAIL %s: got %0h expected %0h", nm, act, exp); end
  endtask

  task automatic clear();
    rd_n = 0; ev_n = 0; rd_first = -1; ev_first = -1;
    hs_idx.delete(); hs_own.delete(); hs_last.delete(); hs_bid.delete();
    rel_id.delete(); rel_cyc.delete();
  endtask

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic chk_reset_outs();
    chk("rst ready", batch_rdy_ready, 1);
    chk("rst ctl", {rd_req, exec_valid, exec_last, batch_release, busy}, 0);
    chk("rst owner", exec_owner, 0);
    chk("rst ids", {rd_batch_id, rd_index, exec_batch_id, exec_tx_index, batch_release_id}, 0);
    chk("rst txcnt", tx_dispatched, 0);
  endtask

  task automatic offer(input int id, input int cnt);
    tick(); batch_rdy_valid = 1; batch_rdy_id = 8'(id); batch_rdy_count = 6'(cnt);
  endtask

  task automatic wait_rel(input int n);
    int k = 0;
    while (rel_id.size() < n && k < 600) begin @(posedge clk); k++; end
    chk("release count", rel_id.size(), n);
  endtask

  task automatic wait_ev(input int ix);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(exec_valid && exec_tx_index == 6'(ix)) && k < 60);
    chk($sformatf("present idx %0d", ix), exec_valid && exec_tx_index == 6'(ix), 1);
  endtask

  task automatic chk_hs(input int id, input int exp_n);
    chk("hs count", hs_idx.size(), exp_n);
    for (int i = 0; i < hs_idx.size() && i < exp_n; i++) begin
      chk($sformatf("idx b%0d[%0d]", id, i), hs_idx[i], i);
      chk($sformatf("owner b%0d[%0d]", id, i), hs_own[i], owner(8'(id), 6'(i)));
      chk($sformatf("last b%0d[%0d]", id, i), hs_last[i], i == exp_n - 1);
      chk($sformatf("bid b%0d[%0d]", id, i), hs_bid[i], id);
    end
  endtask

  // Full batch with exec_ready high: checks data, latency and release timing.
  task automatic run_batch(input int id, input int cnt, input int exp_n);
    logic [31:0] base; int t0;
    clear(); base = tx_dispatched;
    offer(id, cnt); t0 = cyc;
    tick(); batch_rdy_valid = 0;
    wait_rel(1);
    @(negedge clk);
    chk_hs(id, exp_n);
    if (rel_id.size() > 0) begin
      chk("release id", rel_id[0], id);
      chk("release cycle", rel_cyc[0], t0 + 2 + 3 * exp_n);
    end
    chk("rd_req count", rd_n, exp_n);
    chk("exec_valid cycles", ev_n, exp_n);
    if (exp_n > 0) begin
      chk("first rd_req", rd_first, t0 + 2);
      chk("first exec_valid", ev_first, t0 + 4);
    end
    chk("idle after release", busy, 0);
    chk("tx_dispatched", tx_dispatched, base + 32'(exp_n));
  endtask

  typedef struct {int id; int cnt; int exp_n;} vec_t;
  vec_t tbl[6];

  initial begin
    logic [63:0] own_h;
    int rdh;
    tbl = '{'{5, 3, 3}, '{7, 1, 1}, '{9, 0, 0}, '{12, 60, 48}, '{255, 48, 48}, '{3, 2, 2}};
    repeat (3) @(posedge clk);
    #1 chk_reset_outs();
    rst = 1;
    exec_ready = 1;
    foreach (tbl[i]) run_batch(tbl[i].id, tbl[i].cnt, tbl[i].exp_n);

    // Backpressure on index 1 must freeze the presented transaction.
    exec_ready = 0; clear();
    offer(5, 3); tick(); batch_rdy_valid = 0;
    wait_ev(0);
    tick(); exec_ready = 1;
    tick(); exec_ready = 0;
    wait_ev(1);
    own_h = exec_owner; rdh = rd_n;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) @(negedge clk);
      chk("stall valid", exec_valid, 1);
      chk("stall owner", exec_owner, own_h);
      chk("stall idx", exec_tx_index, 1);
    end
    chk("stall owner value", own_h, owner(5, 1));
    chk("stall no rd_req", rd_n, rdh);
    tick(); exec_ready = 1;
    wait_rel(1);
    chk_hs(5, 3);

    // Five back-to-back offers while the executor is stalled.
    exec_ready = 0; clear();
    for (int j = 0; j < 5; j++) begin
      offer(20 + j, 1);
      chk($sformatf("b2b accept %0d", j), batch_rdy_ready, 1);
    end
    tick(); batch_rdy_valid = 0;
    chk("b2b full", batch_rdy_ready, 0);
    chk("b2b busy", busy, 1);
    exec_ready = 1;
    wait_rel(5);
    for (int j = 0; j < rel_id.size() && j < 5; j++) chk($sformatf("b2b order %0d", j), rel_id[j], 20 + j);

    // Reset during PRESENT of index 1, with another batch queued.
    exec_ready = 0; clear();
    offer(40, 3); offer(41, 2); tick(); batch_rdy_valid = 0;
    wait_ev(0);
    tick(); exec_ready = 1;
    tick(); exec_ready = 0;
    wait_ev(1);
    #1 rst = 0;
    #1 chk_reset_outs();
    chk("no release on reset", rel_id.size(), 0);
    tick(); tick(); rst = 1; exec_ready = 1;
    clear();
    repeat (12) @(posedge clk);
    chk("queue flushed valid", ev_n, 0);
    chk("queue flushed release", rel_id.size(), 0);
    run_batch(42, 2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
